adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NUM_REQ, 3, number of requesters sharing the adder.
REQ-002 Parameter WIDTH, 64, operand and result width in bits.
REQ-003 Parameter ID_W, 2, requester-index width, ceil(log2(NUM_REQ)).
REQ-004 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port req_valid  input  NUM_REQ  per-requester operand-valid.
REQ-007 Port req_ready  output  NUM_REQ  per-requester accept; at most one bit high per cycle.
REQ-008 Port req_a  input  NUM_REQ*WIDTH  flattened operand A; requester i owns bits [i*WIDTH +: WIDTH].
REQ-009 Port req_b  input  NUM_REQ*WIDTH  flattened operand B, same packing as req_a.
REQ-010 Port res_valid  output  1  result register holds a valid sum.
REQ-011 Port res_ready  input  1  consumer accepts the result.
REQ-012 Port res_data  output  WIDTH  registered sum.
REQ-013 Port res_id  output  ID_W  index of the requester that produced res_data.

Function
REQ-014 Grant g SHALL be the first index with req_valid high, searching from rr_ptr upward and wrapping past NUM_REQ-1 to 0.
REQ-015 can_accept = !res_valid || res_ready; req_ready[g] SHALL be high only when any req_valid is high and can_accept is high; all other req_ready bits SHALL be low.
REQ-016 A transfer occurs when req_valid[g] && req_ready[g]; res_data SHALL load (A_g + B_g) mod 2^WIDTH, res_id SHALL load g, res_valid SHALL be set, all on the same edge (latency 1 cycle).
REQ-017 Carry-out SHALL be discarded; no overflow flag.
REQ-018 On a transfer, rr_ptr SHALL load (g+1) mod NUM_REQ; with no transfer, rr_ptr SHALL hold.
REQ-019 If res_valid && res_ready with no transfer, res_valid SHALL clear; res_data and res_id SHALL hold.
REQ-020 Simultaneous result consumption and new transfer SHALL sustain one result per cycle with no bubble.
REQ-021 While res_valid && !res_ready, res_data, res_id and res_valid SHALL hold stable and all req_ready SHALL be low.
REQ-022 With all req_valid low, no state except the res_valid clear of REQ-019 SHALL change.
REQ-023 A requester holding req_valid high SHALL be granted within NUM_REQ transfers (no starvation).
REQ-024 req_ready SHALL not depend on req_a or req_b (no data-to-handshake path).

Reset
REQ-025 While reset is high at a clock edge: res_valid=0, res_data=0, res_id=0, rr_ptr=0; req_ready SHALL be all-zero during any cycle reset is high.
REQ-026 Reset asserted while a result is pending SHALL discard it; no transfer SHALL be recorded in a reset cycle.

Structure
REQ-027 NUM_REQ, WIDTH and ID_W defaults SHALL live in the shared package adder_arb_pkg, along with the grant-index type.
REQ-028 The sum SHALL be computed by one instance of the existing Adder sub-module fed by a grant-indexed mux; the arbiter SHALL contain no other adder except the rr_ptr increment.

Verification
REQ-029 Reset: assert reset 2 cycles with all req_valid=1 -> req_ready=000, res_valid=0, res_data=0, res_id=0.
REQ-030 Single request: req_valid=010, A=5, B=7, res_ready=1 -> next cycle res_valid=1, res_data=12, res_id=1, rr_ptr=2.
REQ-031 Round robin: req_valid=111 held, res_ready=1 from reset -> grants 0,1,2,0 on consecutive cycles, one result per cycle.
REQ-032 Backpressure: result pending, res_ready=0 for 3 cycles with req_valid=001 -> req_ready=000, outputs stable; res_ready=1 -> transfer accepted same cycle, new result next edge.
REQ-033 Wrap-around arithmetic: A=0xFFFF_FFFF_FFFF_FFFF, B=2 -> res_data=1.
REQ-034 Reset mid-stream: reset during round-robin with res_valid=1 -> next cycle res_valid=0, first grant after release goes to requester 0.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared parameters and types for the round-robin adder arbiter.
// Keep NUM_REQ, WIDTH and ID_W consistent: ID_W must equal ceil(log2(NUM_REQ)).
package adder_arb_pkg;

    localparam int NUM_REQ = 3;
    localparam int WIDTH   = 64;
    localparam int ID_W    = 2;

    typedef logic [ID_W-1:0] grant_t;

endpackage

// File: rtl/adder_arbiter_adder.sv
// Combinational modular adder shared by all requesters of the arbiter.
// Any carry out of the top bit is dropped.
module Adder
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = adder_arb_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    assign o_sum = i_a + i_b;

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one adder.
// The sum is stored in a single result register drained through a valid/ready handshake.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NUM_REQ = adder_arb_pkg::NUM_REQ,
    parameter int WIDTH   = adder_arb_pkg::WIDTH,
    parameter int ID_W    = adder_arb_pkg::ID_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_data,
    output logic [ID_W-1:0]          res_id
);

    logic             r_resValid;
    logic [WIDTH-1:0] r_resData;
    grant_t           r_resId;
    grant_t           r_rrPtr;

    logic             w_hiFound;
    logic             w_loFound;
    grant_t           w_hiIdx;
    grant_t           w_loIdx;
    grant_t           w_grant;
    grant_t           w_nextPtr;
    logic             w_canAccept;
    logic             w_transfer;
    logic [WIDTH-1:0] w_opA;
    logic [WIDTH-1:0] w_opB;
    logic [WIDTH-1:0] w_sum;

    // Lowest valid index at or above the pointer wins; otherwise the lowest valid below it.
    always_comb begin
        w_hiFound = 1'b0;
        w_loFound = 1'b0;
        w_hiIdx   = '0;
        w_loIdx   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                if (j >= int'(r_rrPtr)) begin
                    w_hiIdx   = grant_t'(j);
                    w_hiFound = 1'b1;
                end else begin
                    w_loIdx   = grant_t'(j);
                    w_loFound = 1'b1;
                end
            end
        end
    end

    assign w_grant     = w_hiFound ? w_hiIdx : w_loIdx;
    assign w_canAccept = !r_resValid || res_ready;
    assign w_transfer  = !reset && (w_hiFound || w_loFound) && w_canAccept;
    assign req_ready   = w_transfer ? (NUM_REQ'(1) << w_grant) : '0;
    assign w_nextPtr   = (w_grant == grant_t'(NUM_REQ - 1)) ? '0 : w_grant + grant_t'(1);

    assign w_opA = req_a[int'(w_grant)*WIDTH +: WIDTH];
    assign w_opB = req_b[int'(w_grant)*WIDTH +: WIDTH];

    Adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_a   (w_opA),
        .i_b   (w_opB),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resValid <= 1'b0;
            r_resData  <= '0;
            r_resId    <= '0;
            r_rrPtr    <= '0;
        end else if (w_transfer) begin
            r_resValid <= 1'b1;
            r_resData  <= w_sum;
            r_resId    <= w_grant;
            r_rrPtr    <= w_nextPtr;
        end else if (r_resValid && res_ready) begin
            r_resValid <= 1'b0;
        end
    end

    assign res_valid = r_resValid;
    assign res_data  = r_resData;
    assign res_id    = r_resId;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed vector table followed by
// randomized traffic compared against an abstract round-robin model.
module tb_adder_arbiter;

    localparam int N = 3;
    localparam int W = 64;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             res_valid;
    logic             res_ready;
    logic [W-1:0]     res_data;
    logic [1:0]       res_id;

    int nChecks = 0;
    int nErrors = 0;

    // Abstract model state
    int           mPtr;
    logic         mValid;
    logic [W-1:0] mData;
    int           mId;

    typedef struct {
        logic            rst;
        logic [N-1:0]    valid;
        logic [N-1:0][W-1:0] a;
        logic [N-1:0][W-1:0] b;
        logic            rdy;
        logic [N-1:0]    expReady;
        logic            expValid;
        logic [W-1:0]    expData;
        int              expId;
    } vec_t;

    vec_t vecs[$];

    adder_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] opOf(input logic [N*W-1:0] bus, input int i);
        return bus[i*W +: W];
    endfunction

    // Model expectation for req_ready given current inputs; also returns the grant.
    task automatic modelReady(output logic [N-1:0] rdyExp, output int g);
        rdyExp = '0;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (mPtr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        if (reset || g < 0 || !(!mValid || res_ready)) g = -1;
        if (g >= 0) rdyExp[g] = 1'b1;
    endtask

    // Drive one cycle; compares to the model, or to the table vector when useVec is set.
    task automatic applyStimulus(input logic rst, input logic [N-1:0] valid,
                                 input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                                 input logic rdy, input bit useVec, input vec_t v);
        logic [N-1:0] rdyExp;
        int g;
        @(negedge clk);
        reset     = rst;
        req_valid = valid;
        req_a     = a;
        req_b     = b;
        res_ready = rdy;
        #1;
        modelReady(rdyExp, g);
        checkOutput("req_ready", W'(req_ready), W'(useVec ? v.expReady : rdyExp));
        if (rst) begin
            mValid = 1'b0; mData = '0; mId = 0; mPtr = 0;
        end else if (g >= 0) begin
            mValid = 1'b1;
            mData  = opOf(a, g) + opOf(b, g);
            mId    = g;
            mPtr   = (g + 1) % N;
        end else if (mValid && rdy) begin
            mValid = 1'b0;
        end
        @(posedge clk);
        #1;
        checkOutput("res_valid", W'(res_valid), W'(useVec ? v.expValid : mValid));
        checkOutput("res_data", res_data, useVec ? v.expData : mData);
        checkOutput("res_id", W'(res_id), useVec ? W'(v.expId) : W'(mId));
    endtask

    task automatic addVec(input logic rst, input logic [N-1:0] valid,
                          input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] a2,
                          input logic [W-1:0] b0, input logic [W-1:0] b1, input logic [W-1:0] b2,
                          input logic rdy, input logic [N-1:0] er, input logic ev,
                          input logic [W-1:0] ed, input int eid);
        vec_t v;
        v.rst = rst; v.valid = valid; v.rdy = rdy;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
        v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
        v.expReady = er; v.expValid = ev; v.expData = ed; v.expId = eid;
        vecs.push_back(v);
    endtask

    initial begin
        logic [W-1:0] allOnes;
        allOnes   = '1;
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        mPtr = 0; mValid = 1'b0; mData = '0; mId = 0;

        // Reset with everyone requesting, then a single request from requester 1
        addVec(1, 3'b111, 1, 2, 3, 4, 5, 6, 1, 3'b000, 0, 0, 0);
        addVec(1, 3'b111, 1, 2, 3, 4, 5, 6, 1, 3'b000, 0, 0, 0);
        addVec(0, 3'b010, 0, 5, 0, 0, 7, 0, 1, 3'b010, 1, 12, 1);
        // Pointer now at 2, so requester 2 goes first
        addVec(0, 3'b111, 10, 20, 30, 1, 2, 3, 1, 3'b100, 1, 33, 2);
        addVec(0, 3'b111, 10, 20, 30, 1, 2, 3, 1, 3'b001, 1, 11, 0);
        addVec(0, 3'b111, 10, 20, 30, 1, 2, 3, 1, 3'b010, 1, 22, 1);
        // Reset mid-stream with a result pending
        addVec(1, 3'b111, 10, 20, 30, 1, 2, 3, 1, 3'b000, 0, 0, 0);
        addVec(0, 3'b111, 10, 20, 30, 1, 2, 3, 1, 3'b001, 1, 11, 0);
        addVec(0, 3'b111, 10, 20, 30, 1, 2, 3, 1, 3'b010, 1, 22, 1);
        addVec(0, 3'b111, 10, 20, 30, 1, 2, 3, 1, 3'b100, 1, 33, 2);
        addVec(0, 3'b111, 10, 20, 30, 1, 2, 3, 1, 3'b001, 1, 11, 0);
        // Backpressure: result must hold for three cycles
        addVec(0, 3'b001, 40, 0, 0, 4, 0, 0, 0, 3'b000, 1, 11, 0);
        addVec(0, 3'b001, 40, 0, 0, 4, 0, 0, 0, 3'b000, 1, 11, 0);
        addVec(0, 3'b001, 40, 0, 0, 4, 0, 0, 0, 3'b000, 1, 11, 0);
        // Release with a wrapping sum
        addVec(0, 3'b001, allOnes, 0, 0, 2, 0, 0, 1, 3'b001, 1, 1, 0);
        addVec(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 3'b000, 0, 1, 0);
        addVec(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].valid, vecs[i].a, vecs[i].b,
                          vecs[i].rdy, 1'b1, vecs[i]);
        end

        // Pointer should now sit at 1: requester 1 outranks 0 and 2
        begin
            vec_t v;
            v.rst = 0; v.valid = 3'b111; v.rdy = 1;
            v.a = '0; v.b = '0;
            v.a[1] = 100; v.b[1] = 23;
            v.expReady = 3'b010; v.expValid = 1; v.expData = 123; v.expId = 1;
            applyStimulus(v.rst, v.valid, v.a, v.b, v.rdy, 1'b1, v);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            logic [N*W-1:0] ra;
            logic [N*W-1:0] rb;
            vec_t dummy;
            dummy = '{default: '0};
            for (int i = 0; i < N * 2; i++) begin
                ra[i*32 +: 32] = $urandom;
                rb[i*32 +: 32] = $urandom;
            end
            if ($urandom_range(0, 7) == 0) ra[W-1:0] = '1;
            applyStimulus(($urandom_range(0, 39) == 0), N'($urandom_range(0, 7)), ra, rb,
                          ($urandom_range(0, 3) != 0), 1'b0, dummy);
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
